// File: rtl/hex_dec_pkg.sv
// Shared widths, FSM encoding and round-robin helper for the hex_dec_arbiter block.
package hex_dec_pkg;

    localparam int unsigned HEX_W   = 8;
    localparam int unsigned DEC_W   = 12;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_e;

    // First set request strictly after ptr, wrapping modulo n; returns ptr if none set.
    function automatic logic [IDX_W-1:0] rr_next_idx(input logic [MAX_REQ-1:0] req,
                                                     input logic [IDX_W-1:0]   ptr,
                                                     input int unsigned        n);
        logic [IDX_W-1:0] idx;
        logic [31:0]      cand;
        idx = ptr;
        // Walk from farthest to nearest so the nearest hit is assigned last.
        for (int unsigned i = n; i >= 1; i--) begin
            cand = (32'(ptr) + i) % n;
            if (req[cand[IDX_W-1:0]]) begin
                idx = cand[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_dec_rr_pick.sv
// Combinational round-robin picker: winner is the first request after the pointer.
module hex_dec_rr_pick
    import hex_dec_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext  = MAX_REQ'(req_i);
        valid_o  = |req_i;
        idx_o    = rr_next_idx(req_ext, ptr_i, N_REQ);
        winner_o = valid_o ? (N_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/hex_to_decimal.sv
// 8-bit binary to 3-digit BCD converter with a fixed LATENCY-stage output pipeline.
module Hex_To_Decimal
    import hex_dec_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic             i_Clk,
    input  logic [HEX_W-1:0] i_Hex,
    output logic [DEC_W-1:0] o_Dec
);

    logic [DEC_W-1:0] bcd;
    logic [DEC_W-1:0] pipe [LATENCY];

    // Double dabble: add 3 to any digit >= 5 before each shift.
    always_comb begin
        logic [DEC_W+HEX_W-1:0] s;
        s = {{DEC_W{1'b0}}, i_Hex};
        for (int i = 0; i < HEX_W; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (s[HEX_W + 4*d +: 4] >= 4'd5) begin
                    s[HEX_W + 4*d +: 4] = s[HEX_W + 4*d +: 4] + 4'd3;
                end
            end
            s = s << 1;
        end
        bcd = s[HEX_W +: DEC_W];
    end

    always_ff @(posedge i_Clk) begin
        pipe[0] <= bcd;
        for (int k = 1; k < int'(LATENCY); k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    assign o_Dec = pipe[LATENCY-1];

endmodule

// File: rtl/hex_dec_arbiter.sv
// Round-robin arbiter sharing one Hex_To_Decimal converter among N_REQ requesters.
// Define HEX_DEC_ARB_STATS_EN to add saturating per-requester grant counters (o_Grant_Count).
module hex_dec_arbiter
    import hex_dec_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CONV_LATENCY = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [N_REQ-1:0]       i_Req,
    input  logic [HEX_W*N_REQ-1:0] i_Hex,
    output logic [N_REQ-1:0]       o_Grant,
    output logic [N_REQ-1:0]       o_Done,
    output logic [DEC_W-1:0]       o_Dec,
    output logic                   o_Busy
`ifdef HEX_DEC_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]    o_Grant_Count
`endif
);

    localparam int unsigned CNT_W = $clog2(CONV_LATENCY + 1);

    state_e           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [HEX_W-1:0] operand;
    logic [DEC_W-1:0] conv_dec;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [HEX_W-1:0] pick_hex;

    hex_dec_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i    (i_Req),
        .ptr_i    (ptr),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        pick_hex = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (pick_onehot[k]) begin
                pick_hex = i_Hex[HEX_W*k +: HEX_W];
            end
        end
    end

    Hex_To_Decimal #(
        .LATENCY (CONV_LATENCY)
    ) u_conv (
        .i_Clk (i_Clk),
        .i_Hex (operand),
        .o_Dec (conv_dec)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state   <= ST_IDLE;
            ptr     <= IDX_W'(N_REQ - 1);
            cnt     <= '0;
            operand <= '0;
            o_Grant <= '0;
            o_Done  <= '0;
            o_Dec   <= '0;
            o_Busy  <= 1'b0;
        end else begin
            o_Grant <= '0;
            o_Done  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        o_Grant <= pick_onehot;
                        operand <= pick_hex;
                        ptr     <= pick_idx;
                        cnt     <= '0;
                        state   <= ST_CONVERT;
                        o_Busy  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(CONV_LATENCY)) begin
                        o_Dec  <= conv_dec;
                        o_Done <= N_REQ'(1) << ptr;
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HEX_DEC_ARB_STATS_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Grant_Count <= '0;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (o_Grant[k] && o_Grant_Count[16*k +: 16] != 16'hFFFF) begin
                    o_Grant_Count[16*k +: 16] <= o_Grant_Count[16*k +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
